// File: rtl/sram_access_ctrl.sv
// AHB-to-SRAM access sequencer: write data-phase issue, same-group read deferral, read data mux.
// Optional SRAM_CONFLICT_CNT_EN adds a saturating conflict_cnt output.
module sram_access_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int NUM_GROUPS = 4,
  parameter int GRP_W      = 2,
  parameter int GRP_LSB    = 12
) (
  input  logic                    hclk,
  input  logic                    n_hreset,
  input  logic                    valid_access,
  input  logic                    hready_in,
  input  logic                    hwrite,
  input  logic [ADDR_W-1:0]       haddr,
  input  logic [2:0]              hsize,
  input  logic [31:0]             hwdata,
  input  logic [32*NUM_GROUPS-1:0] mem_rdata,
  output logic [NUM_GROUPS-1:0]   mem_cs,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [ADDR_W-3:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [31:0]             hrdata,
  output logic                    RWconflict
`ifdef SRAM_CONFLICT_CNT_EN
  ,
  output logic [15:0]             conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_DEFER
  } state_t;

  state_t            state;
  logic [ADDR_W-3:0] wr_addr_q;
  logic [3:0]        wr_be_q;
  logic [GRP_W-1:0]  wr_grp_q;
  logic [ADDR_W-3:0] dr_addr_q;
  logic [GRP_W-1:0]  dr_grp_q;
  logic              rd_vld_q;
  logic [GRP_W-1:0]  rd_grp_q;
  logic [31:0]       hrdata_q;

  logic [GRP_W-1:0]  grp;
  logic              acc_ok;
  logic              rd_req;
  logic              wr_req;
  logic              conflict;
  logic              rd_now;
  logic [3:0]        be_new;
  logic [31:0]       rd_sel;

  assign grp      = haddr[GRP_LSB +: GRP_W];
  assign acc_ok   = valid_access & hready_in & (state != RD_DEFER);
  assign rd_req   = acc_ok & ~hwrite;
  assign wr_req   = acc_ok & hwrite;
  assign conflict = rd_req & (state == WR_DATA) & (grp == wr_grp_q);
  assign rd_now   = rd_req & ~conflict;
  assign rd_sel   = mem_rdata[32*int'(rd_grp_q) +: 32];

  assign RWconflict = conflict;
  assign hrdata     = rd_vld_q ? rd_sel : hrdata_q;

  // Byte lane enables from size and low address bits
  always_comb begin
    be_new = 4'b0000;
    unique case (hsize)
      3'b000:  be_new = 4'b0001 << haddr[1:0];
      3'b001:  be_new = haddr[1] ? 4'b1100 : 4'b0011;
      3'b010:  be_new = 4'b1111;
      default: be_new = 4'b0000;
    endcase
  end

  // SRAM strobes: pending write, deferred read, and live read may overlap
  always_comb begin
    mem_cs    = '0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WR_DATA) begin
      mem_cs[wr_grp_q] = 1'b1;
      mem_we           = 1'b1;
      mem_be           = wr_be_q;
      mem_addr         = wr_addr_q;
      mem_wdata        = hwdata;
    end
    if (state == RD_DEFER) begin
      mem_cs[dr_grp_q] = 1'b1;
      mem_addr         = dr_addr_q;
    end
    if (rd_now) begin
      mem_cs[grp] = 1'b1;
      if (state != WR_DATA) mem_addr = haddr[ADDR_W-1:2];
    end
  end

  // Sequencer state, captured access fields and read return tracking
  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      state     <= IDLE;
      wr_addr_q <= '0;
      wr_be_q   <= '0;
      wr_grp_q  <= '0;
      dr_addr_q <= '0;
      dr_grp_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_grp_q  <= '0;
      hrdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE, WR_DATA: begin
          if (wr_req) begin
            state     <= WR_DATA;
            wr_addr_q <= haddr[ADDR_W-1:2];
            wr_be_q   <= be_new;
            wr_grp_q  <= grp;
          end else if (conflict) begin
            state     <= RD_DEFER;
            dr_addr_q <= haddr[ADDR_W-1:2];
            dr_grp_q  <= grp;
          end else begin
            state <= IDLE;
          end
        end
        RD_DEFER: state <= IDLE;
        default:  state <= IDLE;
      endcase
      rd_vld_q <= rd_now | (state == RD_DEFER);
      if (state == RD_DEFER) rd_grp_q <= dr_grp_q;
      else if (rd_now)       rd_grp_q <= grp;
      if (rd_vld_q) hrdata_q <= rd_sel;
    end
  end

`ifdef SRAM_CONFLICT_CNT_EN
  // Saturating count of conflict cycles
  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      conflict_cnt <= '0;
    end else if (conflict && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
